// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin whole-frame arbiter onto one MAC octet stream; truncates runaway frames, forces IFG idle after each frame.
// One-cycle grant latency, then zero-latency passthrough; MAC backpressure reaches only the owning source.
module eth_tx_frame_arbiter #(
    parameter int NUM_SOURCES      = 3,
    parameter int IFG_CYCLES       = 12,
    parameter int MAX_FRAME_OCTETS = 1518
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [8*NUM_SOURCES-1:0] i_s_data,
    input  logic [NUM_SOURCES-1:0]   i_s_valid,
    input  logic [NUM_SOURCES-1:0]   i_s_last,
    output logic [NUM_SOURCES-1:0]   o_s_ready,
    output logic [7:0]               o_m_data,
    output logic                     o_m_valid,
    output logic                     o_m_last,
    output logic                     o_m_user,
    input  logic                     i_m_ready,
    output logic [NUM_SOURCES-1:0]   o_grant,
    output logic                     o_truncated
);
    localparam int IW = $clog2(NUM_SOURCES);
    localparam int CW = $clog2(MAX_FRAME_OCTETS);
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_GAP} state_t;

    state_t                 r_state;
    logic [NUM_SOURCES-1:0] r_grant;
    logic [IW-1:0]          r_ptr;
    logic [CW-1:0]          r_cnt;
    logic [GW-1:0]          r_gap;
    logic                   r_trunc;

    logic [IW-1:0] w_arb_idx;
    logic [IW-1:0] w_arb_nxt;
    logic          w_arb_vld;
    logic [7:0]    w_g_data;
    logic          w_g_valid;
    logic          w_g_last;
    logic          w_at_limit;
    logic          w_trunc;

    // Lowest valid index overall is the wrap-around fallback; lowest at/after the pointer overrides it.
    always_comb begin
        w_arb_vld = 1'b0;
        w_arb_idx = '0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (i_s_valid[k]) begin
                w_arb_vld = 1'b1;
                w_arb_idx = IW'(k);
            end
        end
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (i_s_valid[k] && (IW'(k) >= r_ptr)) begin
                w_arb_idx = IW'(k);
            end
        end
    end

    assign w_arb_nxt = (w_arb_idx == IW'(NUM_SOURCES - 1)) ? '0 : w_arb_idx + 1'b1;

    always_comb begin
        w_g_data  = '0;
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (r_grant[k]) begin
                w_g_data  = i_s_data[8*k +: 8];
                w_g_valid = i_s_valid[k];
                w_g_last  = i_s_last[k];
            end
        end
    end

    assign w_at_limit = (r_cnt == CW'(MAX_FRAME_OCTETS - 1));
    assign w_trunc    = (r_state == S_STREAM) && w_g_valid && !w_g_last && w_at_limit;

    always_comb begin
        o_m_data  = '0;
        o_m_valid = 1'b0;
        o_m_last  = 1'b0;
        o_m_user  = 1'b0;
        o_s_ready = '0;
        case (r_state)
            S_STREAM: begin
                o_m_data  = w_g_data;
                o_m_valid = w_g_valid;
                o_m_last  = w_g_last | w_trunc;
                o_m_user  = w_trunc;
                o_s_ready = r_grant & {NUM_SOURCES{i_m_ready}};
            end
            S_DRAIN: o_s_ready = r_grant;
            default: ;
        endcase
    end

    assign o_grant     = r_grant;
    assign o_truncated = r_trunc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_vld) begin
                        r_grant <= NUM_SOURCES'(1) << w_arb_idx;
                        r_ptr   <= w_arb_nxt;
                        r_cnt   <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_g_valid && i_m_ready) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_g_last) begin
                            r_grant <= '0;
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end else if (w_at_limit) begin
                            r_trunc <= 1'b1;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_g_valid && w_g_last) begin
                        r_grant <= '0;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(IFG_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: per-source octet scoreboards, frame order, gap and truncation checks.
module tb_eth_tx_frame_arbiter;
    localparam int N    = 3;
    localparam int IFG  = 12;
    localparam int MAXO = 64;
    // Idle cycles between frames as seen on o_grant: the forced gap plus the one-cycle arbitration in IDLE.
    localparam int GRANT_GAP = IFG + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } oct_t;

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic           m_ready = 1'b1;
    logic [7:0]     s_data  [N];
    logic           s_valid [N];
    logic           s_last  [N];
    logic [8*N-1:0] i_s_data;
    logic [N-1:0]   i_s_valid;
    logic [N-1:0]   i_s_last;
    logic [N-1:0]   o_s_ready;
    logic [N-1:0]   o_grant;
    logic [7:0]     o_m_data;
    logic           o_m_valid;
    logic           o_m_last;
    logic           o_m_user;
    logic           o_truncated;

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign i_s_data[8*k +: 8] = s_data[k];
        assign i_s_valid[k]       = s_valid[k];
        assign i_s_last[k]        = s_last[k];
    end

    eth_tx_frame_arbiter #(
        .NUM_SOURCES     (N),
        .IFG_CYCLES      (IFG),
        .MAX_FRAME_OCTETS(MAXO)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_s_data   (i_s_data),
        .i_s_valid  (i_s_valid),
        .i_s_last   (i_s_last),
        .o_s_ready  (o_s_ready),
        .o_m_data   (o_m_data),
        .o_m_valid  (o_m_valid),
        .o_m_last   (o_m_last),
        .o_m_user   (o_m_user),
        .i_m_ready  (m_ready),
        .o_grant    (o_grant),
        .o_truncated(o_truncated)
    );

    always #5 clk = ~clk;

    int   n_checks  = 0;
    int   n_errors  = 0;
    oct_t exp_q [N][$];
    int   order_q[$];
    int   gap_q[$];
    int   trunc_cnt = 0;
    int   out_cnt   = 0;
    int   idle_run  = 0;
    logic exp_trunc = 1'b0;
    logic frame_done = 1'b0;
    logic t3_done   = 1'b0;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] pat(input int src, input int fid, input int p);
        return 8'(p * 5 + src * 71 + fid * 29);
    endfunction

    always @(negedge clk) begin : mon
        int   src;
        oct_t e;
        if (rst) begin
            exp_trunc  = 1'b0;
            frame_done = 1'b0;
            idle_run   = 0;
        end else begin
            check("trunc_pulse", int'(o_truncated), int'(exp_trunc));
            check("ready_onehot", int'($countones(o_s_ready) <= 1), 1);
            check("user_without_last", int'(o_m_user & ~o_m_last), 0);
            exp_trunc = 1'b0;
            if (o_truncated) trunc_cnt++;
            if (o_grant == '0) begin
                idle_run++;
            end else begin
                if (frame_done) gap_q.push_back(idle_run);
                frame_done = 1'b0;
                idle_run   = 0;
            end
            if (o_m_valid && m_ready) begin
                check("grant_onehot", $countones(o_grant), 1);
                src = 0;
                for (int k = 0; k < N; k++) if (o_grant[k]) src = k;
                out_cnt++;
                if (exp_q[src].size() == 0) begin
                    check("unexpected_octet", int'(o_m_data), -1);
                end else begin
                    e = exp_q[src].pop_front();
                    check("octet_data", int'(o_m_data), int'(e.d));
                    check("octet_last", int'(o_m_last), int'(e.l));
                    check("octet_user", int'(o_m_user), int'(e.u));
                    exp_trunc = e.u;
                end
                if (o_m_last) begin
                    order_q.push_back(src);
                    frame_done = 1'b1;
                    idle_run   = 0;
                end
            end
        end
    end

    task automatic wait_ready(input int src);
        int ok;
        ok = 0;
        for (int t = 0; t < 2000 && ok == 0; t++) begin
            @(negedge clk);
            if (o_s_ready[src]) ok = 1;
        end
        if (ok == 0) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Expected output models truncation: octets past the limit never reach the MAC.
    task automatic send_frame(input int src, input int len, input int fid);
        oct_t e;
        for (int p = 0; p < len; p++) begin
            s_data[src]  = pat(src, fid, p);
            s_last[src]  = (p == len - 1);
            s_valid[src] = 1'b1;
            if (p < MAXO) begin
                e.d = pat(src, fid, p);
                e.l = (p == len - 1) || (p == MAXO - 1);
                e.u = (p == MAXO - 1) && (p != len - 1);
                exp_q[src].push_back(e);
            end
            wait_ready(src);
        end
        s_valid[src] = 1'b0;
        s_last[src]  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", int'(o_grant), 0);
        check("rst_s_ready", int'(o_s_ready), 0);
        check("rst_m_valid", int'(o_m_valid), 0);
        check("rst_m_last", int'(o_m_last), 0);
        check("rst_m_user", int'(o_m_user), 0);
        check("rst_truncated", int'(o_truncated), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        order_q.delete();
        gap_q.delete();
        out_cnt   = 0;
        trunc_cnt = 0;
    endtask

    task automatic check_empty(input string tag);
        for (int k = 0; k < N; k++) check(tag, exp_q[k].size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int exp2[6];
        exp2 = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < N; k++) begin
            s_data[k]  = '0;
            s_valid[k] = 1'b0;
            s_last[k]  = 1'b0;
        end

        // Test 1: two back-to-back 60-octet frames from source 0.
        do_reset();
        clear_logs();
        fork
            begin
                send_frame(0, 60, 1);
                send_frame(0, 60, 2);
            end
            begin
                @(negedge clk);
                check("t1_grant_latency0", int'(o_grant), 0);
                @(negedge clk);
                check("t1_grant_latency1", int'(o_grant), 1);
            end
        join
        check("t1_out_cnt", out_cnt, 120);
        check("t1_frames", order_q.size(), 2);
        check("t1_gaps", gap_q.size(), 1);
        foreach (gap_q[i]) check("t1_gap_len", gap_q[i], GRANT_GAP);
        check_empty("t1_sb_empty");

        // Test 2: all sources continuously requesting, two 64-octet frames each.
        do_reset();
        clear_logs();
        fork
            begin send_frame(0, 64, 3); send_frame(0, 64, 4); end
            begin send_frame(1, 64, 3); send_frame(1, 64, 4); end
            begin send_frame(2, 64, 3); send_frame(2, 64, 4); end
        join
        check("t2_frames", order_q.size(), 6);
        foreach (order_q[i]) if (i < 6) check("t2_order", order_q[i], exp2[i]);
        check("t2_gaps", gap_q.size(), 5);
        foreach (gap_q[i]) check("t2_gap_len", gap_q[i], GRANT_GAP);
        check("t2_trunc", trunc_cnt, 0);
        check_empty("t2_sb_empty");

        // Test 3: MAC ready toggling during a 46-octet frame from source 1.
        clear_logs();
        t3_done = 1'b0;
        fork
            begin
                send_frame(1, 46, 5);
                t3_done = 1'b1;
            end
            begin
                for (int t = 0; t < 1000 && !t3_done; t++) begin
                    @(posedge clk);
                    #2;
                    m_ready = ~m_ready;
                    @(negedge clk);
                    if (o_grant == 3'b010)
                        check("t3_ready_mirror", int'(o_s_ready), m_ready ? 2 : 0);
                end
            end
        join
        m_ready = 1'b1;
        check("t3_out_cnt", out_cnt, 46);
        check("t3_frames", order_q.size(), 1);
        foreach (order_q[i]) check("t3_order", order_q[i], 1);
        check_empty("t3_sb_empty");

        // Test 4: 100-octet frame from source 2 truncated at 64.
        clear_logs();
        send_frame(2, 100, 6);
        @(negedge clk);
        check("t4_gap_grant", int'(o_grant), 0);
        check("t4_gap_ready", int'(o_s_ready), 0);
        check("t4_out_cnt", out_cnt, 64);
        check("t4_trunc_cnt", trunc_cnt, 1);
        check("t4_frames", order_q.size(), 1);
        foreach (order_q[i]) check("t4_order", order_q[i], 2);
        check_empty("t4_sb_empty");

        // Test 5: reset at octet 20 of a source-0 frame, source 1 pending.
        repeat (IFG + 2) @(posedge clk);
        #1;
        clear_logs();
        for (int p = 0; p < 20; p++) begin
            oct_t e;
            s_data[0]  = pat(0, 7, p);
            s_last[0]  = 1'b0;
            s_valid[0] = 1'b1;
            e.d = pat(0, 7, p);
            e.l = 1'b0;
            e.u = 1'b0;
            exp_q[0].push_back(e);
            wait_ready(0);
        end
        s_data[0] = pat(0, 7, 20);
        rst = 1'b1;
        fork
            send_frame(1, 10, 8);
            begin
                @(posedge clk);
                @(negedge clk);
                check("t5_valid_after_rst", int'(o_m_valid), 0);
                check("t5_grant_after_rst", int'(o_grant), 0);
                check("t5_ready_after_rst", int'(o_s_ready), 0);
                @(posedge clk);
                #1;
                rst        = 1'b0;
                s_valid[0] = 1'b0;
            end
        join
        check("t5_out_cnt", out_cnt, 30);
        check("t5_frames", order_q.size(), 1);
        foreach (order_q[i]) check("t5_order", order_q[i], 1);
        check_empty("t5_sb_empty");

        // Test 6: move the pointer to 0, then a single-octet frame from 1 must move it to 2.
        send_frame(2, 8, 9);
        clear_logs();
        send_frame(1, 1, 10);
        check("t6_out_cnt", out_cnt, 1);
        fork
            send_frame(0, 5, 11);
            send_frame(2, 5, 11);
        join
        check("t6_frames", order_q.size(), 3);
        if (order_q.size() == 3) begin
            check("t6_order0", order_q[0], 1);
            check("t6_order1", order_q[1], 2);
            check("t6_order2", order_q[2], 0);
        end
        check("t6_trunc", trunc_cnt, 0);
        check_empty("t6_sb_empty");

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
